// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encoding, parity modes
// and the baud oversampling ratio.
package uart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start, DBIT data bits LSB-first, optional parity, stop.
// Bit timing comes from a 16x s_tick enable; the line output is registered.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int NW = $clog2(DBIT);
  // Unknown parity modes fall back to no parity.
  localparam bit PAR_EN  = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam bit PAR_INV = (PARITY == PAR_ODD);

  localparam logic [4:0]    LAST_S    = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    LAST_STOP = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] LAST_N    = NW'(DBIT - 1);

  logic [2:0]      state_q, state_d;
  logic [4:0]      s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic            tx_q, tx_d;
  logic            done_c;

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    p_d     = p_q;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          b_d     = din;
          p_d     = (^din) ^ PAR_INV;
          s_cnt_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_S) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_S) begin
            s_cnt_d = '0;
            b_d     = b_q >> 1;
            if (n_cnt_q == LAST_N) state_d = PAR_EN ? PAR : STOP;
            else                   n_cnt_d = n_cnt_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      PAR: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_S) begin
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_STOP) begin
            s_cnt_d = '0;
            state_d = IDLE;
            done_c  = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the next state so tx moves on the transition edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      PAR:     tx_d = p_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_c & ~reset;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four parameterisations share clock and
// baud tick; each task drives one scenario and checks the line tick by tick.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic [1:0] tph = 2'd0;
  logic [3:0] start_r = 4'd0;
  logic [7:0] din = 8'd0;
  logic [3:0] tx_w, busy_w, done_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // One-clk s_tick every 4 clocks, updated away from the active edge.
  always @(negedge clk) begin
    tph    <= tph + 2'd1;
    s_tick <= (tph == 2'd3);
  end

  uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_r[0]), .din(din),
    .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0]));
  uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_r[1]), .din(din),
    .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1]));
  uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_r[2]), .din(din),
    .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2]));
  uart_tx_ctrl #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u3 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start_r[3]), .din(din),
    .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .tx(tx_w[3]));

  // Watches one frame from the sample after the accepting edge until the
  // edge after the done pulse. lv[j] is the line level of bit slot j.
  task automatic frame(input int u, input logic [7:0] d, input bit par_en,
                       input logic pb, input int sb, input bit skip_start,
                       input bit poke, input bit chain, input logic [7:0] d2,
                       input string nm);
    logic [9:0] lv;
    logic       exp;
    int nb, total, k, cyc, limit, errs, berr, bad_k, done_n, done_k, ierr;
    logic bad_got;
    bit poke_live, poked;
    lv = {pb, d, 1'b0};
    nb = par_en ? 10 : 9;
    total = nb * 16 + sb;
    limit = total * 4 + 64;
    k = 0; cyc = 0; errs = 0; berr = 0; bad_k = -1; bad_got = 1'b0;
    done_n = 0; done_k = -1; poke_live = 1'b0; poked = 1'b0;
    if (!skip_start) begin
      @(negedge clk); #1;
      din = d; start_r[u] = 1'b1;
      @(negedge clk); #1;
      start_r[u] = 1'b0;
    end
    while (cyc < limit) begin
      if (poke_live) begin
        start_r[u] = 1'b0; din = 8'h00; poke_live = 1'b0;
      end
      exp = (k / 16 < nb) ? lv[k/16] : 1'b1;
      if (tx_w[u] !== exp) begin
        if (errs == 0) begin bad_k = k; bad_got = tx_w[u]; end
        errs++;
      end
      if (busy_w[u] !== (k < total)) berr++;
      if (done_w[u] === 1'b1) begin done_n++; done_k = k + 1; end
      if (poke && k == 50 && !poked) begin
        din = 8'h3C; start_r[u] = 1'b1; poke_live = 1'b1; poked = 1'b1;
      end
      if (k == total) break;
      if (s_tick) k++;
      @(negedge clk); #1;
      cyc++;
    end
    tests++;
    if (cyc >= limit) begin
      fails++;
      $display("FAIL %s timeout: reached tick %0d, required %0d", nm, k, total);
    end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL %s line: %0d bad samples, first at tick %0d got %b", nm, errs, bad_k, bad_got);
    end
    tests++;
    if (berr != 0) begin
      fails++;
      $display("FAIL %s busy: %0d samples wrong, required 0", nm, berr);
    end
    tests++;
    if (done_n != 1) begin
      fails++;
      $display("FAIL %s done_count: got %0d required 1", nm, done_n);
    end
    tests++;
    if (done_k != total) begin
      fails++;
      $display("FAIL %s done_tick: got %0d required %0d", nm, done_k, total);
    end
    if (chain) begin
      din = d2; start_r[u] = 1'b1;
      @(negedge clk); #1;
      start_r[u] = 1'b0;
    end else begin
      ierr = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); #1;
        if (busy_w[u] !== 1'b0 || tx_w[u] !== 1'b1 || done_w[u] !== 1'b0) ierr++;
      end
      tests++;
      if (ierr != 0) begin
        fails++;
        $display("FAIL %s idle_after: %0d bad cycles, required 0", nm, ierr);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (tx_w !== 4'hF) begin fails++; $display("FAIL reset_tx: got %b required 1111", tx_w); end
    tests++;
    if (busy_w !== 4'h0) begin fails++; $display("FAIL reset_busy: got %b required 0000", busy_w); end
    tests++;
    if (done_w !== 4'h0) begin fails++; $display("FAIL reset_done: got %b required 0000", done_w); end
    reset = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (tx_w !== 4'hF || busy_w !== 4'h0) begin
      fails++; $display("FAIL idle_after_reset: tx %b busy %b required 1111 0000", tx_w, busy_w);
    end
  endtask

  task automatic test_no_parity();
    frame(0, 8'hA5, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 8'h00, "p0_a5");
  endtask

  task automatic test_parity();
    frame(1, 8'hA5, 1'b1, 1'b0, 16, 1'b0, 1'b0, 1'b0, 8'h00, "even_a5");
    frame(2, 8'hA5, 1'b1, 1'b1, 16, 1'b0, 1'b0, 1'b0, 8'h00, "odd_a5");
    frame(1, 8'h01, 1'b1, 1'b1, 16, 1'b0, 1'b0, 1'b0, 8'h00, "even_01");
  endtask

  task automatic test_start_while_busy();
    frame(0, 8'hA5, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0, 8'h00, "busy_poke");
  endtask

  task automatic test_back_to_back();
    frame(0, 8'hA5, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b1, 8'hFF, "b2b_first");
    frame(0, 8'hFF, 1'b0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 8'h00, "b2b_second");
  endtask

  task automatic test_reset_mid_frame();
    int k, cyc, derr;
    k = 0; cyc = 0; derr = 0;
    @(negedge clk); #1;
    din = 8'hA5; start_r[0] = 1'b1;
    @(negedge clk); #1;
    start_r[0] = 1'b0;
    while (k < 70 && cyc < 400) begin
      if (s_tick) k++;
      @(negedge clk); #1;
      cyc++;
    end
    reset = 1'b1;
    if (done_w[0] !== 1'b0) derr++;
    @(negedge clk); #1;
    tests++;
    if (tx_w[0] !== 1'b1) begin fails++; $display("FAIL abort_tx: got %b required 1", tx_w[0]); end
    tests++;
    if (busy_w[0] !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b required 0", busy_w[0]); end
    reset = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) derr++;
    end
    tests++;
    if (derr != 0) begin fails++; $display("FAIL abort_quiet: %0d bad cycles, required 0", derr); end
    frame(0, 8'h55, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b0, 8'h00, "after_abort_55");
  endtask

  task automatic test_long_stop();
    frame(3, 8'hA5, 1'b0, 1'b0, 32, 1'b0, 1'b0, 1'b0, 8'h00, "sb32_a5");
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_long_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end

endmodule
